// File: rtl/tmr0_event_unit.sv
// rtl/tmr0_event_unit.sv - timer overflow/compare event detection, postscaler, IRQ and PWM
// Watches the timer count each cycle and derives sticky flags, a registered irq and pwm_out.
module tmr0_event_unit #(
  parameter int WIDTH  = 8,
  parameter int POST_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  tmr_val,
  input  logic              tmr_load,
  input  logic [WIDTH-1:0]  cmp_val,
  input  logic              cmp_wr,
  input  logic [POST_W-1:0] postscale,
  input  logic              ie_ovf,
  input  logic              ie_cmp,
  input  logic              ack_ovf,
  input  logic              ack_cmp,
  output logic              ovf_flag,
  output logic              cmp_flag,
  output logic              irq,
  output logic              pwm_out
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic              run;
  logic [WIDTH-1:0]  prev;
  logic [POST_W-1:0] post_cnt;
  logic [WIDTH-1:0]  cmp_pend;
  logic [WIDTH-1:0]  cmp_act;
  logic              changed;
  logic              ovf_evt;
  logic              cmp_evt;
  logic              xfer;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // IDLE lasts exactly one cycle: it only exists to make prev valid.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    run = 1'b0;
    case (state)
      RUN:     run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  assign changed = (tmr_val != prev);
  assign ovf_evt = run && changed && !tmr_load && (prev == {WIDTH{1'b1}}) && (tmr_val == '0);
  // A parallel load onto the compare value still counts as a match.
  assign cmp_evt = run && changed && (tmr_val == cmp_act);
  assign xfer    = ovf_evt || tmr_load || !run;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      post_cnt <= '0;
      cmp_pend <= '0;
      cmp_act  <= '0;
      ovf_flag <= 1'b0;
      cmp_flag <= 1'b0;
      irq      <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      prev <= tmr_val;
      if (cmp_wr) cmp_pend <= cmp_val;
      if (xfer)   cmp_act  <= cmp_pend;

      if (ovf_evt) begin
        if (post_cnt == postscale) post_cnt <= '0;
        else                       post_cnt <= post_cnt + 1'b1;
      end

      // Set takes priority over a simultaneous acknowledge.
      if (ovf_evt && (post_cnt == postscale)) ovf_flag <= 1'b1;
      else if (ack_ovf)                       ovf_flag <= 1'b0;

      if (cmp_evt)      cmp_flag <= 1'b1;
      else if (ack_cmp) cmp_flag <= 1'b0;

      irq     <= (ovf_flag & ie_ovf) | (cmp_flag & ie_cmp);
      pwm_out <= (tmr_val < cmp_act);
    end
  end

endmodule

// File: tb/tb_tmr0_event_unit.sv
// tb/tb_tmr0_event_unit.sv - directed self-checking bench for tmr0_event_unit
module tb_tmr0_event_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tmr_val;
  logic       tmr_load;
  logic [7:0] cmp_val;
  logic       cmp_wr;
  logic [3:0] postscale;
  logic       ie_ovf;
  logic       ie_cmp;
  logic       ack_ovf;
  logic       ack_cmp;
  logic       ovf_flag;
  logic       cmp_flag;
  logic       irq;
  logic       pwm_out;

  int errors = 0;
  int checks = 0;
  int wraps  = 0;

  tmr0_event_unit #(.WIDTH(8), .POST_W(4)) dut (
    .clk(clk), .reset(reset), .tmr_val(tmr_val), .tmr_load(tmr_load),
    .cmp_val(cmp_val), .cmp_wr(cmp_wr), .postscale(postscale),
    .ie_ovf(ie_ovf), .ie_cmp(ie_cmp), .ack_ovf(ack_ovf), .ack_cmp(ack_cmp),
    .ovf_flag(ovf_flag), .cmp_flag(cmp_flag), .irq(irq), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic count_to(input logic [7:0] last);
    while (tmr_val != last) begin
      tmr_val = tmr_val + 8'd1;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; tmr_val = 8'h00; tmr_load = 1'b0; cmp_val = 8'h00; cmp_wr = 1'b0;
    postscale = 4'd0; ie_ovf = 1'b1; ie_cmp = 1'b0; ack_ovf = 1'b0; ack_cmp = 1'b0;
    step();
    check("rst_ovf", ovf_flag, 1'b0);
    check("rst_cmp", cmp_flag, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_pwm", pwm_out, 1'b0);

    // Counting overflow FD,FE,FF,00 with postscale 0
    reset = 1'b0; tmr_val = 8'hFD; step();
    tmr_val = 8'hFE; step();
    tmr_val = 8'hFF; step();
    check("pre_ovf", ovf_flag, 1'b0);
    tmr_val = 8'h00; step();
    check("ovf_set", ovf_flag, 1'b1);
    check("ovf_irq_lag", irq, 1'b0);
    check("cmp_at_zero", cmp_flag, 1'b1);
    check("pwm_cmp0", pwm_out, 1'b0);
    tmr_val = 8'h01; step();
    check("ovf_irq", irq, 1'b1);
    ack_ovf = 1'b1; ack_cmp = 1'b1; tmr_val = 8'h02; step();
    check("ack_ovf", ovf_flag, 1'b0);
    check("ack_irq_lag", irq, 1'b1);
    ack_ovf = 1'b0; ack_cmp = 1'b0; cmp_wr = 1'b1; cmp_val = 8'h80; step();
    check("irq_drop", irq, 1'b0);
    cmp_wr = 1'b0;

    // Loaded FF->00 is not an overflow; cmp_act reloads to 0x80
    tmr_val = 8'hFF; step();
    tmr_load = 1'b1; tmr_val = 8'h00; step();
    check("load_no_ovf", ovf_flag, 1'b0);
    check("load_cmp_match", cmp_flag, 1'b1);
    tmr_load = 1'b0; ack_cmp = 1'b1; tmr_val = 8'h10; step();
    check("load_reload_pwm", pwm_out, 1'b1);
    check("load_no_ovf2", ovf_flag, 1'b0);
    ack_cmp = 1'b0;

    // Postscale 2: flag only on the third wrap
    postscale = 4'd2;
    for (int i = 1; i <= 768; i++) begin
      tmr_val = tmr_val + 8'd1;
      step();
      if (tmr_val == 8'h00) begin
        wraps++;
        check($sformatf("post_wrap%0d", wraps), ovf_flag, (wraps == 3));
      end
    end
    // Count must be 0 again: with postscale 0 the next overflow sets the flag
    ack_ovf = 1'b1; ack_cmp = 1'b1; postscale = 4'd0; tmr_load = 1'b1; tmr_val = 8'hFE; step();
    check("post_ack", ovf_flag, 1'b0);
    ack_ovf = 1'b0; ack_cmp = 1'b0; tmr_load = 1'b0;
    tmr_val = 8'hFF; step();
    tmr_val = 8'h00; step();
    check("post_cnt_zero", ovf_flag, 1'b1);

    // Double buffering: write 0x40 during a load transfer; act keeps 0x80 this period
    tmr_load = 1'b1; tmr_val = 8'h10; cmp_wr = 1'b1; cmp_val = 8'h40;
    ack_cmp = 1'b1; ack_ovf = 1'b1; step();
    tmr_load = 1'b0; cmp_wr = 1'b0; ack_cmp = 1'b0; ack_ovf = 1'b0;
    check("db_flag_clr", cmp_flag, 1'b0);
    check("db_pwm_start", pwm_out, 1'b1);
    count_to(8'h7F);
    check("db_pwm_7f", pwm_out, 1'b1);
    check("db_no_match_40", cmp_flag, 1'b0);
    count_to(8'h80);
    check("db_pwm_80", pwm_out, 1'b0);
    check("db_match_80", cmp_flag, 1'b1);
    ack_cmp = 1'b1; count_to(8'h81); ack_cmp = 1'b0;
    count_to(8'hFF);
    tmr_val = 8'h00; step();
    check("db_pwm_wrap", pwm_out, 1'b1);
    check("db_flag_wrap", cmp_flag, 1'b0);
    count_to(8'h3F);
    check("db_pwm_3f", pwm_out, 1'b1);
    count_to(8'h40);
    check("db_pwm_40", pwm_out, 1'b0);
    check("db_match_40", cmp_flag, 1'b1);
    count_to(8'h50);

    // Ack coinciding with a match, enable gating of irq
    ack_ovf = 1'b1; ie_ovf = 1'b0; tmr_load = 1'b1; tmr_val = 8'h3F; step();
    ack_ovf = 1'b0; tmr_load = 1'b0; ack_cmp = 1'b1; tmr_val = 8'h40; step();
    check("set_wins", cmp_flag, 1'b1);
    check("irq_masked", irq, 1'b0);
    ack_cmp = 1'b0; ie_cmp = 1'b1; step();
    check("irq_enable", irq, 1'b1);
    ack_cmp = 1'b1; step();
    check("no_retrigger", cmp_flag, 1'b0);
    ack_cmp = 1'b0; step();
    check("irq_after_ack", irq, 1'b0);

    // Reset while tmr_val wraps
    ie_cmp = 1'b0; ie_ovf = 1'b1; tmr_val = 8'hFF; step();
    reset = 1'b1; step();
    check("mid_rst_ovf", ovf_flag, 1'b0);
    check("mid_rst_pwm", pwm_out, 1'b0);
    reset = 1'b0; tmr_val = 8'h00; step();
    check("idle_no_ovf", ovf_flag, 1'b0);
    check("idle_no_cmp", cmp_flag, 1'b0);
    check("idle_pwm", pwm_out, 1'b0);
    tmr_val = 8'hFF; step();
    check("run_no_ovf", ovf_flag, 1'b0);
    tmr_val = 8'h00; step();
    check("run_ovf", ovf_flag, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
